// File: rtl/id_ex_operand_stage_if.sv
// ID-to-EX instruction bus: decoded instruction fields from ID and the ready back-pressure.
interface id_ex_operand_stage_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  id_valid;
  logic                  id_ready;
  logic [XLEN-1:0]       id_pc;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [3:0]            id_alu_ctrl;
  logic                  id_src1_pc;
  logic                  id_src2_imm;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl, id_src1_pc, id_src2_imm,
           id_rd_addr, id_reg_write, id_mem_read, id_mem_write,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl, id_src1_pc, id_src2_imm,
           id_rd_addr, id_reg_write, id_mem_read, id_mem_write,
    output id_ready
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion and MEM/WB operand forwarding
// feeding the execute-stage ALU.
module id_ex_operand_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  id_ex_operand_stage_if.slave  id,
  input  logic                  flush,
  input  logic                  ex_stall,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic                  mem_is_load,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_op1,
  output logic [XLEN-1:0]       ex_op2,
  output logic [3:0]            ex_alu_ctrl,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  load_use_stall
);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [3:0]            alu_ctrl;
    logic                  src1_pc;
    logic                  src2_imm;
  } payload_t;

  payload_t pl_q;
  payload_t pl_d;
  logic     valid_q;
  logic     reg_write_q;
  logic     mem_read_q;
  logic     mem_write_q;
  logic     hz;

  always_comb begin
    pl_d          = '0;
    pl_d.pc       = id.id_pc;
    pl_d.imm      = id.id_imm;
    pl_d.rs1_data = id.id_rs1_data;
    pl_d.rs2_data = id.id_rs2_data;
    pl_d.rs1_addr = id.id_rs1_addr;
    pl_d.rs2_addr = id.id_rs2_addr;
    pl_d.rd_addr  = id.id_rd_addr;
    pl_d.alu_ctrl = id.id_alu_ctrl;
    pl_d.src1_pc  = id.id_src1_pc;
    pl_d.src2_imm = id.id_src2_imm;
  end

  // Load in EX whose destination is read by the instruction waiting in ID.
  assign hz = valid_q & mem_read_q & (pl_q.rd_addr != '0) &
              ((id.id_rs1_used & (id.id_rs1_addr == pl_q.rd_addr)) |
               (id.id_rs2_used & (id.id_rs2_addr == pl_q.rd_addr)));

  assign load_use_stall = id.id_valid & hz & ~flush & ~ex_stall;
  assign id.id_ready    = ~ex_stall & ~hz & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl_q        <= '0;
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!ex_stall) begin
      if (hz) begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end else begin
        pl_q        <= pl_d;
        valid_q     <= id.id_valid;
        reg_write_q <= id.id_valid & id.id_reg_write;
        mem_read_q  <= id.id_valid & id.id_mem_read;
        mem_write_q <= id.id_valid & id.id_mem_write;
      end
    end
  end

  // MEM wins over WB; loads in MEM have no data yet, and x0 is never forwarded.
  logic            mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  assign mem_hit1 = valid_q & mem_reg_write & ~mem_is_load & (mem_rd_addr != '0) &
                    (mem_rd_addr == pl_q.rs1_addr);
  assign mem_hit2 = valid_q & mem_reg_write & ~mem_is_load & (mem_rd_addr != '0) &
                    (mem_rd_addr == pl_q.rs2_addr);
  assign wb_hit1  = valid_q & wb_reg_write & (wb_rd_addr != '0) & (wb_rd_addr == pl_q.rs1_addr);
  assign wb_hit2  = valid_q & wb_reg_write & (wb_rd_addr != '0) & (wb_rd_addr == pl_q.rs2_addr);

  assign fwd_rs1 = mem_hit1 ? mem_fwd_data : (wb_hit1 ? wb_data : pl_q.rs1_data);
  assign fwd_rs2 = mem_hit2 ? mem_fwd_data : (wb_hit2 ? wb_data : pl_q.rs2_data);

  assign ex_op1        = pl_q.src1_pc  ? pl_q.pc  : fwd_rs1;
  assign ex_op2        = pl_q.src2_imm ? pl_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_alu_ctrl   = pl_q.alu_ctrl;
  assign ex_pc         = pl_q.pc;
  assign ex_imm        = pl_q.imm;
  assign ex_rd_addr    = pl_q.rd_addr;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// instruction-level model of the EX slot.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, ex_stall;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, mem_is_load, wb_reg_write;
  logic [31:0] mem_fwd_data, wb_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
  logic [31:0] ex_op1, ex_op2, ex_store_data, ex_pc, ex_imm;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd_addr;

  int tests = 0;
  int errors = 0;

  id_ex_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) idb ();

  id_ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id(idb), .flush(flush), .ex_stall(ex_stall),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_fwd_data(mem_fwd_data), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // The instruction currently sitting in EX, as the model sees it.
  typedef struct {
    bit          valid;
    logic [31:0] pc, imm, rs1d, rs2d;
    logic [4:0]  rs1a, rs2a, rd;
    logic [3:0]  alu;
    bit          s1pc, s2imm, rw, mr, mw;
  } slot_t;

  slot_t m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (mem_reg_write && mem_rd_addr != 0 && mem_rd_addr == a && !mem_is_load) return mem_fwd_data;
    if (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == a) return wb_data;
    return rf;
  endfunction

  function automatic bit ref_hazard();
    if (!(m.valid && m.mr && m.rd != 0)) return 0;
    return (idb.id_rs1_used && idb.id_rs1_addr == m.rd) ||
           (idb.id_rs2_used && idb.id_rs2_addr == m.rd);
  endfunction

  task automatic check_model();
    bit h;
    h = ref_hazard();
    check("id_ready", 32'(idb.id_ready), 32'(!ex_stall && !h && !flush));
    check("load_use_stall", 32'(load_use_stall), 32'(idb.id_valid && h && !flush && !ex_stall));
    check("ex_valid", 32'(ex_valid), 32'(m.valid));
    if (m.valid) begin
      check("ex_op1", ex_op1, m.s1pc ? m.pc : ref_fwd(m.rs1a, m.rs1d));
      check("ex_op2", ex_op2, m.s2imm ? m.imm : ref_fwd(m.rs2a, m.rs2d));
      check("ex_store_data", ex_store_data, ref_fwd(m.rs2a, m.rs2d));
      check("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(m.alu));
      check("ex_pc", ex_pc, m.pc);
      check("ex_imm", ex_imm, m.imm);
      check("ex_rd_addr", 32'(ex_rd_addr), 32'(m.rd));
      check("ex_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, {29'd0, m.rw, m.mr, m.mw});
    end
  endtask

  function automatic slot_t ref_next();
    slot_t n;
    n = m;
    if (flush) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    end else if (ex_stall) begin
      n = m;
    end else if (ref_hazard()) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    end else begin
      n.valid = idb.id_valid;
      n.pc = idb.id_pc; n.imm = idb.id_imm;
      n.rs1d = idb.id_rs1_data; n.rs2d = idb.id_rs2_data;
      n.rs1a = idb.id_rs1_addr; n.rs2a = idb.id_rs2_addr; n.rd = idb.id_rd_addr;
      n.alu = idb.id_alu_ctrl; n.s1pc = idb.id_src1_pc; n.s2imm = idb.id_src2_imm;
      n.rw = idb.id_valid && idb.id_reg_write;
      n.mr = idb.id_valid && idb.id_mem_read;
      n.mw = idb.id_valid && idb.id_mem_write;
    end
    return n;
  endfunction

  // Called just after a falling edge with inputs set; returns just after the next falling edge.
  task automatic step();
    slot_t n;
    #1;
    check_model();
    n = ref_next();
    @(posedge clk);
    m = n;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    idb.id_valid = 0; idb.id_pc = 0; idb.id_rs1_addr = 0; idb.id_rs2_addr = 0;
    idb.id_rs1_used = 0; idb.id_rs2_used = 0; idb.id_rs1_data = 0; idb.id_rs2_data = 0;
    idb.id_imm = 0; idb.id_alu_ctrl = 0; idb.id_src1_pc = 0; idb.id_src2_imm = 0;
    idb.id_rd_addr = 0; idb.id_reg_write = 0; idb.id_mem_read = 0; idb.id_mem_write = 0;
    flush = 0; ex_stall = 0;
    mem_rd_addr = 0; mem_reg_write = 0; mem_is_load = 0; mem_fwd_data = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  task automatic reset_now();
    #2 rst_n = 0;
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_op1", ex_op1, 32'd0);
    check("rst_ex_op2", ex_op2, 32'd0);
    check("rst_ex_store_data", ex_store_data, 32'd0);
    m = '{default: '0};
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic rand_inputs();
    idle_inputs();
    idb.id_valid = ($urandom_range(0, 3) != 0);
    idb.id_pc = $urandom; idb.id_imm = $urandom;
    idb.id_rs1_addr = 5'($urandom_range(0, 7)); idb.id_rs2_addr = 5'($urandom_range(0, 7));
    idb.id_rs1_used = 1'($urandom); idb.id_rs2_used = 1'($urandom);
    idb.id_rs1_data = $urandom; idb.id_rs2_data = $urandom;
    idb.id_alu_ctrl = 4'($urandom); idb.id_src1_pc = 1'($urandom); idb.id_src2_imm = 1'($urandom);
    idb.id_rd_addr = 5'($urandom_range(0, 7));
    idb.id_reg_write = 1'($urandom); idb.id_mem_read = ($urandom_range(0, 2) == 0);
    idb.id_mem_write = 1'($urandom);
    flush = ($urandom_range(0, 7) == 0); ex_stall = ($urandom_range(0, 3) == 0);
    mem_rd_addr = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom);
    mem_is_load = 1'($urandom); mem_fwd_data = $urandom;
    wb_rd_addr = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom); wb_data = $urandom;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    m = '{default: '0};
    #7;
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_ex_op1", ex_op1, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // MEM forward onto rs1
    idb.id_valid = 1; idb.id_rs1_addr = 5; idb.id_rs1_used = 1; idb.id_rs1_data = 32'h1;
    idb.id_rd_addr = 9; idb.id_reg_write = 1; idb.id_alu_ctrl = 4'b0000;
    step();
    idle_inputs();
    mem_reg_write = 1; mem_rd_addr = 5; mem_fwd_data = 32'h10;
    #1;
    check("memfwd_op1", ex_op1, 32'h10);
    check("memfwd_alu", 32'(ex_alu_ctrl), 32'h0);
    step();

    // MEM beats WB on rs2, then x0 is never forwarded
    idb.id_valid = 1; idb.id_rs2_addr = 6; idb.id_rs2_used = 1; idb.id_rs2_data = 32'h3;
    step();
    idle_inputs();
    mem_reg_write = 1; mem_rd_addr = 6; mem_fwd_data = 32'hAAAA0000;
    wb_reg_write = 1; wb_rd_addr = 6; wb_data = 32'h5555;
    #1;
    check("prio_op2", ex_op2, 32'hAAAA0000);
    step();
    idb.id_valid = 1; idb.id_rs1_addr = 0; idb.id_rs1_used = 1;
    step();
    idle_inputs();
    mem_reg_write = 1; mem_rd_addr = 0; mem_fwd_data = 32'hFFFFFFFF;
    #1;
    check("x0_op1", ex_op1, 32'h0);
    step();

    // Load-use: lw x7 followed by add x8,x7,x1
    idb.id_valid = 1; idb.id_rd_addr = 7; idb.id_reg_write = 1; idb.id_mem_read = 1;
    step();
    idle_inputs();
    idb.id_valid = 1; idb.id_rs1_addr = 7; idb.id_rs2_addr = 1; idb.id_rs1_used = 1;
    idb.id_rs2_used = 1; idb.id_rd_addr = 8; idb.id_reg_write = 1; idb.id_rs1_data = 32'hDEAD;
    #1;
    check("lu_stall", 32'(load_use_stall), 32'd1);
    check("lu_ready", 32'(idb.id_ready), 32'd0);
    step();
    #1;
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    check("lu_stall_gone", 32'(load_use_stall), 32'd0);
    step();
    idle_inputs();
    wb_reg_write = 1; wb_rd_addr = 7; wb_data = 32'h1234;
    #1;
    check("lu_add_valid", 32'(ex_valid), 32'd1);
    check("lu_add_op1", ex_op1, 32'h1234);
    step();

    // Stall holds EX for 3 cycles, then flush wins over stall
    idb.id_valid = 1; idb.id_pc = 32'h200; idb.id_rd_addr = 4; idb.id_reg_write = 1;
    step();
    idb.id_pc = 32'h204; ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc_held", ex_pc, 32'h200);
      check("stall_ready", 32'(idb.id_ready), 32'd0);
    end
    flush = 1;
    step();
    check("flush_over_stall", 32'(ex_valid), 32'd0);
    idle_inputs();

    // PC/immediate select with forwarded store data
    idb.id_valid = 1; idb.id_src1_pc = 1; idb.id_src2_imm = 1; idb.id_pc = 32'h100;
    idb.id_imm = 32'hFFFFFFFC; idb.id_rs2_addr = 3; idb.id_rs2_used = 1; idb.id_rs2_data = 32'h77;
    step();
    idle_inputs();
    mem_reg_write = 1; mem_rd_addr = 3; mem_fwd_data = 32'hBEEF;
    #1;
    check("sel_op1", ex_op1, 32'h100);
    check("sel_op2", ex_op2, 32'hFFFFFFFC);
    check("sel_store", ex_store_data, 32'hBEEF);
    step();

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      if (i == 300) reset_now();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
